// File: rtl/dcnn_io_coordinator.sv
// DCNN I/O coordinator: streams input words into RAM behind a layer header and reads class scores back.
// Define COORD_ARGMAX_EN to read NUM_CLASSES scores and report the argmax; otherwise one score byte is read.
module dcnn_io_coordinator #(
    parameter int DIN_W       = 16,
    parameter int RAM_DW      = 8,
    parameter int ADDR_W      = 16,
    parameter int OUT_W       = 4,
    parameter int NUM_CLASSES = 10,
    parameter int LAYER_SHIFT = 12,
    parameter logic [ADDR_W-1:0] RESULT_BASE = ADDR_W'(16'hF000)
) (
    input  logic              clk,
    input  logic              RST,
    input  logic              load,
    input  logic              cnn,
    input  logic              interrupt,
    input  logic [DIN_W-1:0]  Din,
    input  logic              din_valid,
    input  logic              din_last,
    output logic              din_ready,
    input  logic [15:0]       layerIndex,
    input  logic [2:0]        layerType,
    output logic [ADDR_W-1:0] ramAddress,
    output logic [RAM_DW-1:0] ramDataOut,
    input  logic [RAM_DW-1:0] ramDataIn,
    output logic              readSignal,
    output logic              writeSignal,
    input  logic              ramDone,
    output logic [OUT_W-1:0]  Dout,
    output logic              dout_valid,
    output logic              busy,
    output logic              done,
    output logic [2:0]        stateDbg
);

`ifdef COORD_ARGMAX_EN
    localparam bit ArgmaxEn = 1'b1;
`else
    localparam bit ArgmaxEn = 1'b0;
`endif

    localparam int NB       = DIN_W / RAM_DW;
    localparam int KW       = (NB > 1) ? $clog2(NB) : 1;
    localparam int IW       = OUT_W + 1;
    localparam int NumReads = ArgmaxEn ? NUM_CLASSES : 1;
    localparam logic [KW-1:0] LastByte = KW'(NB - 1);
    localparam logic [IW-1:0] LastRead = IW'(NumReads - 1);

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_HDR_WR    = 3'd1;
    localparam logic [2:0] S_LOAD_WAIT = 3'd2;
    localparam logic [2:0] S_LOAD_WR   = 3'd3;
    localparam logic [2:0] S_RES_RD    = 3'd4;
    localparam logic [2:0] S_RES_OUT   = 3'd5;

    logic [2:0]               state;
    logic [ADDR_W-1:0]        baseAddr;
    logic [ADDR_W-1:0]        ptr;
    logic [2:0]               typeQ;
    logic [DIN_W-1:0]         wordQ;
    logic                     lastQ;
    logic [KW-1:0]            byteIdx;
    logic [IW-1:0]            scoreIdx;
    logic [OUT_W-1:0]         bestIdx;
    logic signed [RAM_DW-1:0] bestScore;
    logic [ADDR_W-1:0]        layerBase;

    assign layerBase = ADDR_W'(64'(layerIndex) << LAYER_SHIFT);

    // Din handshake: a word moves on a rising edge where din_valid && din_ready;
    // din_ready is high only while waiting for a word, so it falls on the transfer edge.
    assign din_ready = (state == S_LOAD_WAIT);
    assign busy      = (state != S_IDLE);
    assign stateDbg  = state;

    // RAM strobes rise with address/data already stable, hold through the ramDone
    // cycle and fall on the next edge, which leaves at least one idle cycle between requests.
    always_ff @(posedge clk or negedge RST) begin
        if (!RST) begin
            state       <= S_IDLE;
            baseAddr    <= '0;
            ptr         <= '0;
            typeQ       <= '0;
            wordQ       <= '0;
            lastQ       <= 1'b0;
            byteIdx     <= '0;
            scoreIdx    <= '0;
            bestIdx     <= '0;
            bestScore   <= '0;
            ramAddress  <= '0;
            ramDataOut  <= '0;
            readSignal  <= 1'b0;
            writeSignal <= 1'b0;
            Dout        <= '0;
            dout_valid  <= 1'b0;
            done        <= 1'b0;
        end else begin
            done <= 1'b0;
            if (interrupt && (state != S_IDLE)) begin
                state       <= S_IDLE;
                readSignal  <= 1'b0;
                writeSignal <= 1'b0;
                dout_valid  <= 1'b0;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (load) begin
                            baseAddr   <= layerBase;
                            typeQ      <= layerType;
                            dout_valid <= 1'b0;
                            state      <= S_HDR_WR;
                        end else if (cnn) begin
                            scoreIdx   <= '0;
                            bestIdx    <= '0;
                            bestScore  <= {1'b1, {(RAM_DW-1){1'b0}}};
                            dout_valid <= 1'b0;
                            state      <= S_RES_RD;
                        end
                    end
                    S_HDR_WR: begin
                        if (!writeSignal) begin
                            writeSignal <= 1'b1;
                            ramAddress  <= baseAddr;
                            ramDataOut  <= RAM_DW'(typeQ);
                        end else if (ramDone) begin
                            writeSignal <= 1'b0;
                            ptr         <= baseAddr + ADDR_W'(1);
                            state       <= S_LOAD_WAIT;
                        end
                    end
                    S_LOAD_WAIT: begin
                        if (din_valid) begin
                            wordQ   <= Din;
                            lastQ   <= din_last;
                            byteIdx <= '0;
                            state   <= S_LOAD_WR;
                        end
                    end
                    S_LOAD_WR: begin
                        // The word is shifted down after each byte, so the low byte is always next.
                        if (!writeSignal) begin
                            writeSignal <= 1'b1;
                            ramAddress  <= ptr;
                            ramDataOut  <= wordQ[RAM_DW-1:0];
                        end else if (ramDone) begin
                            writeSignal <= 1'b0;
                            ptr         <= ptr + ADDR_W'(1);
                            wordQ       <= wordQ >> RAM_DW;
                            byteIdx     <= byteIdx + KW'(1);
                            if (byteIdx == LastByte) begin
                                if (lastQ) begin
                                    done  <= 1'b1;
                                    state <= S_IDLE;
                                end else begin
                                    state <= S_LOAD_WAIT;
                                end
                            end
                        end
                    end
                    S_RES_RD: begin
                        if (!readSignal) begin
                            readSignal <= 1'b1;
                            ramAddress <= RESULT_BASE + ADDR_W'(scoreIdx);
                        end else if (ramDone) begin
                            readSignal <= 1'b0;
                            scoreIdx   <= scoreIdx + IW'(1);
                            if (ArgmaxEn) begin
                                // Strictly greater only: ties keep the lower class index.
                                if ($signed(ramDataIn) > bestScore) begin
                                    bestScore <= $signed(ramDataIn);
                                    bestIdx   <= scoreIdx[OUT_W-1:0];
                                end
                            end else begin
                                bestIdx <= ramDataIn[OUT_W-1:0];
                            end
                            if (scoreIdx == LastRead) begin
                                state <= S_RES_OUT;
                            end
                        end
                    end
                    S_RES_OUT: begin
                        Dout       <= bestIdx;
                        dout_valid <= 1'b1;
                        done       <= 1'b1;
                        state      <= S_IDLE;
                    end
                    default: begin
                        state <= S_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_dcnn_io_coordinator.sv
// Bench for dcnn_io_coordinator: RAM responder with random latency, write/read scoreboards and a
// reference model of the header/byte layout and the result-session rule.
module tb_dcnn_io_coordinator;

    localparam int DIN_W       = 16;
    localparam int RAM_DW      = 8;
    localparam int ADDR_W      = 16;
    localparam int OUT_W       = 4;
    localparam int NUM_CLASSES = 10;
    localparam int LAYER_SHIFT = 12;
    localparam int NBYTES      = DIN_W / RAM_DW;
    localparam logic [15:0] RESULT_BASE = 16'hF000;
`ifdef COORD_ARGMAX_EN
    localparam int NREADS = NUM_CLASSES;
`else
    localparam int NREADS = 1;
`endif

    // clock / reset
    logic clk = 1'b0;
    logic RST = 1'b0;
    always #5 clk = ~clk;

    logic              load = 1'b0, cnn = 1'b0, interrupt = 1'b0;
    logic [DIN_W-1:0]  Din = '0;
    logic              din_valid = 1'b0, din_last = 1'b0, din_ready;
    logic [15:0]       layerIndex = '0;
    logic [2:0]        layerType = '0;
    logic [ADDR_W-1:0] ramAddress;
    logic [RAM_DW-1:0] ramDataOut;
    logic [RAM_DW-1:0] ramDataIn = '0;
    logic              readSignal, writeSignal;
    logic              ramDone = 1'b0;
    logic [OUT_W-1:0]  Dout;
    logic              dout_valid, busy, done;
    logic [2:0]        stateDbg;

    dcnn_io_coordinator #(
        .DIN_W(DIN_W), .RAM_DW(RAM_DW), .ADDR_W(ADDR_W), .OUT_W(OUT_W),
        .NUM_CLASSES(NUM_CLASSES), .LAYER_SHIFT(LAYER_SHIFT), .RESULT_BASE(RESULT_BASE)
    ) dut (
        .clk(clk), .RST(RST), .load(load), .cnn(cnn), .interrupt(interrupt),
        .Din(Din), .din_valid(din_valid), .din_last(din_last), .din_ready(din_ready),
        .layerIndex(layerIndex), .layerType(layerType),
        .ramAddress(ramAddress), .ramDataOut(ramDataOut), .ramDataIn(ramDataIn),
        .readSignal(readSignal), .writeSignal(writeSignal), .ramDone(ramDone),
        .Dout(Dout), .dout_valid(dout_valid), .busy(busy), .done(done), .stateDbg(stateDbg)
    );

    // scoreboard state
    int total = 0;
    int bad   = 0;
    logic [23:0] exp_q[$];
    logic [15:0] exp_rd_q[$];
    logic [15:0] words_q[$];
    logic [7:0]  mem [0:65535];
    int done_cnt = 0, rd_cnt = 0, wr_cnt = 0;
    int lat_max = 2;
    logic [15:0] last_wr_addr = '0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (RST && done) done_cnt++;
    end

    // RAM responder
    bit          in_req = 1'b0;
    int          wait_left = 0;
    logic [15:0] req_addr;
    logic [7:0]  req_data;
    always @(negedge clk) begin
        if (!RST) begin
            ramDone = 1'b0;
            in_req  = 1'b0;
        end else if (ramDone) begin
            ramDone = 1'b0;
            in_req  = 1'b0;
            check("strobe_drop", {readSignal, writeSignal}, 2'b00);
        end else if (!(readSignal || writeSignal)) begin
            in_req = 1'b0;
        end else begin
            if (!in_req) begin
                in_req    = 1'b1;
                wait_left = $urandom_range(lat_max, 0);
                req_addr  = ramAddress;
                req_data  = ramDataOut;
            end else begin
                check("req_stable", {ramAddress, ramDataOut}, {req_addr, req_data});
            end
            if (wait_left == 0) begin
                ramDone = 1'b1;
                if (writeSignal) begin
                    mem[ramAddress] = ramDataOut;
                    wr_cnt++;
                    last_wr_addr = ramAddress;
                    check("wr_expected", exp_q.size() > 0, 1);
                    if (exp_q.size() > 0) check("wr", {ramAddress, ramDataOut}, exp_q.pop_front());
                end else begin
                    ramDataIn = mem[ramAddress];
                    rd_cnt++;
                    check("rd_expected", exp_rd_q.size() > 0, 1);
                    if (exp_rd_q.size() > 0) check("rd_addr", ramAddress, exp_rd_q.pop_front());
                end
            end else begin
                wait_left--;
            end
        end
    end

    // reference model: header byte at the layer base, then little-endian bytes, addresses mod 2^16
    function automatic void model_load(input int idx, input int typ);
        int b;
        int ptr;
        b = (idx * (1 << LAYER_SHIFT)) % 65536;
        exp_q.push_back({16'(b), 8'(typ)});
        ptr = (b + 1) % 65536;
        foreach (words_q[w]) begin
            for (int k = 0; k < NBYTES; k++) begin
                exp_q.push_back({16'(ptr), 8'((int'(words_q[w]) / (1 << (8 * k))) % 256)});
                ptr = (ptr + 1) % 65536;
            end
        end
    endfunction

    function automatic int model_result();
`ifdef COORD_ARGMAX_EN
        int best;
        int idx;
        int s;
        best = -1000;
        idx  = 0;
        for (int i = 0; i < NUM_CLASSES; i++) begin
            s = int'(mem[RESULT_BASE + i]);
            if (s > 127) s = s - 256;
            if (s > best) begin
                best = s;
                idx  = i;
            end
        end
        return idx;
`else
        return int'(mem[RESULT_BASE]) % 16;
`endif
    endfunction

    task automatic do_load(input int idx, input int typ, input bit also_cnn, input bit cnn_mid);
        int n;
        int d0;
        int rd0;
        d0  = done_cnt;
        rd0 = rd_cnt;
        model_load(idx, typ);
        layerIndex = 16'(idx);
        layerType  = 3'(typ);
        load = 1'b1;
        cnn  = also_cnn;
        tick();
        load = 1'b0;
        cnn  = 1'b0;
        check("load_busy", busy, 1);
        check("load_clr_valid", dout_valid, 0);
        foreach (words_q[i]) begin
            repeat ($urandom_range(2, 0)) tick();
            Din       = words_q[i];
            din_valid = 1'b1;
            din_last  = (i == words_q.size() - 1);
            n = 0;
            while (!din_ready && n < 100) begin
                tick();
                n++;
            end
            check("din_ready_wait", n < 100, 1);
            tick();
            din_valid = 1'b0;
            din_last  = 1'b0;
            Din       = 16'($urandom);
            check("din_ready_drop", din_ready, 0);
            if (cnn_mid && i == 0) begin
                cnn = 1'b1;
                tick();
                tick();
                cnn = 1'b0;
            end
        end
        n = 0;
        while (!done && n < 200) begin
            tick();
            n++;
        end
        check("load_done", done, 1);
        check("done_busy", busy, 0);
        tick();
        check("done_pulse", done_cnt - d0, 1);
        check("done_low", done, 0);
        check("wr_all", exp_q.size(), 0);
        check("load_no_reads", rd_cnt - rd0, 0);
        words_q.delete();
    endtask

    task automatic do_result();
        int n;
        int d0;
        int rd0;
        int e;
        d0  = done_cnt;
        rd0 = rd_cnt;
        e   = model_result();
        for (int i = 0; i < NREADS; i++) exp_rd_q.push_back(16'(RESULT_BASE + i));
        cnn = 1'b1;
        tick();
        cnn = 1'b0;
        check("res_busy", busy, 1);
        check("res_clr_valid", dout_valid, 0);
        n = 0;
        while (!done && n < 300) begin
            tick();
            n++;
        end
        check("res_done", done, 1);
        check("res_dout", Dout, e);
        check("res_valid", dout_valid, 1);
        check("res_reads", rd_cnt - rd0, NREADS);
        check("rd_all", exp_rd_q.size(), 0);
        tick();
        check("res_pulse", done_cnt - d0, 1);
        check("res_valid_hold", dout_valid, 1);
    endtask

    initial begin
        int n;
        int d0;
        logic [OUT_W-1:0] prev;
        for (int a = 0; a < 65536; a++) mem[a] = 8'h00;

        // reset state
        repeat (3) tick();
        check("rst_outs", {ramAddress, ramDataOut, readSignal, writeSignal, din_ready, Dout, dout_valid, busy, done}, 64'd0);
        RST = 1'b1;
        tick();
        check("rst_idle_busy", busy, 0);

        // directed load
        words_q = '{16'hBEEF, 16'h1234};
        do_load(2, 3, 1'b0, 1'b0);

        // random loads
        for (int r = 0; r < 3; r++) begin
            n = $urandom_range(6, 1);
            for (int w = 0; w < n; w++) words_q.push_back(16'($urandom));
            do_load($urandom_range(14, 0), $urandom_range(7, 0), 1'b0, 1'b0);
        end

        // load and cnn together: load wins; cnn pulsed while busy is ignored
        words_q = '{16'($urandom), 16'($urandom)};
        do_load($urandom_range(14, 0), $urandom_range(7, 0), 1'b1, 1'b0);
        words_q = '{16'($urandom), 16'($urandom), 16'($urandom)};
        do_load($urandom_range(14, 0), $urandom_range(7, 0), 1'b0, 1'b1);

        // result sessions
        for (int i = 0; i < NUM_CLASSES; i++) mem[RESULT_BASE + i] = 8'h00;
        mem[RESULT_BASE]     = 8'd5;
        mem[RESULT_BASE + 1] = 8'hFD;
        mem[RESULT_BASE + 2] = 8'd9;
        mem[RESULT_BASE + 3] = 8'd9;
        do_result();
        for (int i = 0; i < NUM_CLASSES; i++) mem[RESULT_BASE + i] = 8'h80;
        do_result();
        for (int i = 1; i < NUM_CLASSES; i++) mem[RESULT_BASE + i] = 8'($urandom);
        mem[RESULT_BASE] = 8'h27;
        do_result();
        for (int r = 0; r < 4; r++) begin
            for (int i = 0; i < NUM_CLASSES; i++) mem[RESULT_BASE + i] = 8'($urandom);
            do_result();
        end

        // interrupt at the start of a result session
        prev = 4'(model_result());
        d0 = done_cnt;
        cnn = 1'b1;
        tick();
        cnn = 1'b0;
        interrupt = 1'b1;
        tick();
        interrupt = 1'b0;
        check("irq_res_dout", Dout, prev);
        check("irq_res_valid", dout_valid, 0);
        check("irq_res_busy", busy, 0);
        check("irq_res_rd", readSignal, 0);
        repeat (3) tick();
        check("irq_res_nodone", done_cnt - d0, 0);

        // interrupt during byte 1 of a load word, coincident with ramDone
        lat_max = 0;
        words_q = '{16'hA5C3};
        model_load(3, 5);
        words_q.delete();
        layerIndex = 16'd3;
        layerType  = 3'd5;
        load = 1'b1;
        tick();
        load = 1'b0;
        Din = 16'hA5C3;
        din_valid = 1'b1;
        din_last  = 1'b1;
        n = 0;
        while (!din_ready && n < 50) begin
            tick();
            n++;
        end
        tick();
        din_valid = 1'b0;
        din_last  = 1'b0;
        n = 0;
        while (!(writeSignal && ramAddress == 16'h3002) && n < 50) begin
            tick();
            n++;
        end
        check("irq_reach", n < 50, 1);
        d0 = done_cnt;
        interrupt = 1'b1;
        tick();
        interrupt = 1'b0;
        check("irq_busy", busy, 0);
        check("irq_wr", writeSignal, 0);
        check("irq_done", done, 0);
        check("irq_din_ready", din_ready, 0);
        repeat (5) tick();
        check("irq_nodone", done_cnt - d0, 0);
        check("irq_wr_idle", writeSignal, 0);
        exp_q.delete();

        // asynchronous reset in the middle of a read
        lat_max = 2;
        mem[RESULT_BASE] = 8'h3C;
        for (int i = 0; i < NREADS; i++) exp_rd_q.push_back(16'(RESULT_BASE + i));
        cnn = 1'b1;
        tick();
        cnn = 1'b0;
        n = 0;
        while (!readSignal && n < 50) begin
            tick();
            n++;
        end
        check("rst_mid_reach", readSignal, 1);
        #2 RST = 1'b0;
        #1;
        check("rst_mid_outs", {ramAddress, ramDataOut, readSignal, writeSignal, din_ready, Dout, dout_valid, busy, done}, 64'd0);
        @(posedge clk);
        #3 RST = 1'b1;
        exp_rd_q.delete();
        tick();
        for (int i = 0; i < NUM_CLASSES; i++) mem[RESULT_BASE + i] = 8'($urandom);
        do_result();

        // pointer wrap: base 0xF000, header + 4096 bytes puts the final byte at 0x0000
        lat_max = 0;
        for (int w = 0; w < 2048; w++) words_q.push_back(16'($urandom));
        do_load(15, $urandom_range(7, 0), 1'b0, 1'b0);
        check("wrap_last_addr", last_wr_addr, 16'h0000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL global_timeout total=%0d bad=%0d", total, bad);
        $fatal(1, "timeout");
    end

endmodule
